// File: rtl/eh2_dec_gpr_wb_buf.sv
// rtl/eh2_dec_gpr_wb_buf.sv - FIFO of late GPR writebacks sharing one GPR file write port
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     late result handshake (in_tid, in_waddr, in_wd)
//   port_busy             pipeline owns the GPR write port this cycle
//   flush[1:0]            per-thread kill of buffered entries
//   wen/wtid/waddr/wd     GPR file write port (all zero when wen is 0)
//   pending_t0/t1[31:1]   registers with a buffered, unkilled write per thread
//   count                 occupied entries, including killed ones
module eh2_dec_gpr_wb_buf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_tid,
  input  logic [4:0]  in_waddr,
  input  logic [31:0] in_wd,
  input  logic        port_busy,
  input  logic [1:0]  flush,
  output logic        wen,
  output logic        wtid,
  output logic [4:0]  waddr,
  output logic [31:0] wd,
  output logic [31:1] pending_t0,
  output logic [31:1] pending_t1,
  output logic [3:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [PW-1:0]    head_q, tail_q;
  logic [3:0]       count_q;
  logic [DEPTH-1:0] occ_q, kill_q;
  logic             tid_q  [DEPTH];
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic head_occ, head_kill, head_tid;
  logic wen_int, pop, accept, enq;

  assign head_occ  = occ_q[head_q];
  assign head_kill = kill_q[head_q];
  assign head_tid  = tid_q[head_q];

  // A head whose thread is being flushed this cycle is held back; its kill
  // bit lands on this edge and it drains silently next cycle.
  assign wen_int = head_occ & ~head_kill & ~port_busy & ~flush[head_tid];
  assign pop     = wen_int | (head_occ & head_kill);

  // Full means full: a same-cycle pop does not open a slot for the push.
  assign in_ready = (count_q < DEPTH_C);
  assign accept   = in_valid & in_ready;
  // x0 writes and pushes racing a flush of their own thread are swallowed.
  assign enq      = accept & (|in_waddr) & ~flush[in_tid];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      kill_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ_q[i] && flush[tid_q[i]]) kill_q[i] <= 1'b1;
      end
      if (pop) begin
        occ_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      // The tail slot is never occupied when a push is taken, so it cannot
      // collide with the pop or the kill update above.
      if (enq) begin
        occ_q[tail_q]  <= 1'b1;
        kill_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + PW'(1);
      end
      if (enq && !pop)      count_q <= count_q + 4'd1;
      else if (!enq && pop) count_q <= count_q - 4'd1;
    end
  end

  // Payload needs no reset: occ_q qualifies every use of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      tid_q[tail_q]  <= in_tid;
      addr_q[tail_q] <= in_waddr;
      data_q[tail_q] <= in_wd;
    end
  end

  always_comb begin
    pending_t0 = '0;
    pending_t1 = '0;
    for (int j = 1; j < 32; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ_q[i] && !kill_q[i] && (addr_q[i] == 5'(j))) begin
          if (tid_q[i]) pending_t1[j] = 1'b1;
          else          pending_t0[j] = 1'b1;
        end
      end
    end
  end

  assign wen   = wen_int;
  assign wtid  = wen_int & head_tid;
  assign waddr = wen_int ? addr_q[head_q] : 5'd0;
  assign wd    = wen_int ? data_q[head_q] : 32'd0;
  assign count = count_q;

endmodule

// File: tb/tb_eh2_dec_gpr_wb_buf.sv
// tb/tb_eh2_dec_gpr_wb_buf.sv - scoreboard bench for eh2_dec_gpr_wb_buf
module tb_eh2_dec_gpr_wb_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_tid;
  logic [4:0]  in_waddr;
  logic [31:0] in_wd;
  logic        port_busy;
  logic [1:0]  flush;
  logic        wen;
  logic        wtid;
  logic [4:0]  waddr;
  logic [31:0] wd;
  logic [31:1] pending_t0;
  logic [31:1] pending_t1;
  logic [3:0]  count;

  eh2_dec_gpr_wb_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid),
    .in_waddr(in_waddr), .in_wd(in_wd),
    .port_busy(port_busy), .flush(flush),
    .wen(wen), .wtid(wtid), .waddr(waddr), .wd(wd),
    .pending_t0(pending_t0), .pending_t1(pending_t1), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        tid;
    bit [4:0]  waddr;
    bit [31:0] wd;
    bit        killed;
  } ent_t;

  ent_t mq[$];     // reference buffer contents, oldest first
  ent_t exp_q[$];  // writes the port must show, in order

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, advance the model
  // across the following rising edge, check state outputs before that edge.
  task automatic cyc(input bit v, input bit t, input bit [4:0] a, input bit [31:0] d,
                     input bit b, input bit [1:0] f);
    bit [31:0] p0, p1;
    int        sz;
    bit        acc;
    ent_t      e;
    @(negedge clk);
    in_valid = v; in_tid = t; in_waddr = a; in_wd = d; port_busy = b; flush = f;
    p0 = '0; p1 = '0;
    foreach (mq[i]) if (!mq[i].killed) begin
      if (mq[i].tid) p1[mq[i].waddr] = 1'b1;
      else           p0[mq[i].waddr] = 1'b1;
    end
    sz  = mq.size();
    acc = v && (sz < DEPTH);
    if (sz > 0) begin
      if (mq[0].killed) begin
        e = mq.pop_front();
      end else if (!b && !f[mq[0].tid]) begin
        e = mq.pop_front();
        exp_q.push_back(e);
      end
    end
    foreach (mq[i]) if (f[mq[i].tid]) mq[i].killed = 1'b1;
    if (acc && a != 5'd0 && !f[t]) begin
      e.tid = t; e.waddr = a; e.wd = d; e.killed = 1'b0;
      mq.push_back(e);
    end
    #2;
    chk("count", 64'(count), 64'(sz));
    chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
    chk("pending_t0", 64'({pending_t0, 1'b0}), 64'({p0[31:1], 1'b0}));
    chk("pending_t1", 64'({pending_t1, 1'b0}), 64'({p1[31:1], 1'b0}));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 2'b00);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 0; in_tid = 0; in_waddr = 0; in_wd = 0; port_busy = 0; flush = 0;
    rst = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_port", 64'({wtid, waddr, wd}), 64'd0);
    chk("rst_pending", 64'({pending_t0, pending_t1}), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: consumes expected writes whenever the DUT drives the port.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (wen) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_wen: got tid %0d addr %0d data %0h expected no write",
                     wtid, waddr, wd);
          end else begin
            e = exp_q.pop_front();
            chk("write", 64'({wtid, waddr, wd}), 64'({e.tid, e.waddr, e.wd}));
          end
        end else begin
          chk("idle_port", 64'({wtid, waddr, wd}), 64'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; in_tid = 0; in_waddr = 0; in_wd = 0; port_busy = 0; flush = 0;
    #1;
    chk("init_count", 64'(count), 64'd0);
    chk("init_ready", 64'(in_ready), 64'd1);
    do_reset();

    // single write
    cyc(1, 0, 5'd5, 32'hDEADBEEF, 0, 2'b00);
    idle(3);

    // full and backpressure
    for (int k = 0; k < 4; k++) cyc(1, k[0], 5'(k + 10), 32'h1000 + k, 1, 2'b00);
    cyc(1, 0, 5'd20, 32'hBAD0BAD0, 1, 2'b00);
    idle(6);

    // flush thread 0 while thread 1 survives
    cyc(1, 0, 5'd3, 32'h33, 1, 2'b00);
    cyc(1, 1, 5'd7, 32'h77, 1, 2'b00);
    cyc(1, 0, 5'd9, 32'h99, 1, 2'b00);
    cyc(0, 0, 5'd0, 32'h0, 1, 2'b01);
    cyc(0, 0, 5'd0, 32'h0, 1, 2'b00);
    idle(5);

    // same register twice
    cyc(1, 1, 5'd4, 32'd1, 1, 2'b00);
    cyc(1, 1, 5'd4, 32'd2, 1, 2'b00);
    idle(4);

    // x0 discard and wrap-around streaming
    cyc(1, 0, 5'd0, 32'h12345678, 0, 2'b00);
    idle(1);
    for (int k = 0; k < 10; k++) cyc(1, k[1], 5'(k + 1), 32'hA000 + k, k[2], 2'b00);
    idle(6);

    // reset with three entries buffered
    for (int k = 0; k < 3; k++) cyc(1, 0, 5'(k + 1), 32'hC0 + k, 1, 2'b00);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit [4:0] a;
      bit [1:0] f;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      f = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      cyc($urandom_range(0, 9) < 7, 1'($urandom), a, $urandom, 1'($urandom), f);
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    idle(10);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
